uart_calc_parser: RTL and testbench
===================================

# uart_calc_parser

Byte-stream command parser and arithmetic core for the UART calculator. Sits directly downstream of the UART receiver: consumes each received byte (`rx_data` qualified by a one-cycle `rx_valid` pulse), assembles an ASCII expression of the form `<A><op><B><term>`, evaluates it, and presents a signed result with a valid/ready handshake to the transmit-side formatter.

## Interface
- `OPW`, 16, operand width in bits; operands are unsigned decimal, 0 to 2^OPW-1
- `RESW`, 32, result width; must be ≥ 2*OPW; result is two's-complement signed
- `clk` input 1 — system clock
- `rst` input 1 — reset, asynchronous, active-high
- `rx_data` input 8 — received byte, valid only when `rx_valid`=1
- `rx_valid` input 1 — one-cycle pulse per received byte
- `res_ready` input 1 — downstream accepts result
- `res_data` output RESW — signed result
- `res_valid` output 1 — result available; held until accepted
- `res_err` output 1 — result is an error report; meaningful when `res_valid`=1
- `busy` output 1 — high in CALC and OUT states

## Operation
- States: IDLE, OPA, OPB, CALC, OUT.
- IDLE: `acc_a`=`acc_b`=0, `err`=0. A digit moves to OPA and loads the digit. `+`,`-`,`*`, `=`, or CR sets `err` and moves to OPA.
- Digit (0x30–0x39): `acc = acc*10 + (byte-0x30)` in the current operand register. If the true value exceeds 2^OPW-1, set `err`; the register keeps its previous value.
- Space (0x20): ignored in every state. LF (0x0A): ignored in every state.
- OPA: `+`, `-`, `*` latch the operator and move to OPB. Operator with no digit seen sets `err` and still moves to OPB.
- OPB: digits accumulate into `acc_b`. A second operator sets `err`.
- Terminator `=` (0x3D) or CR (0x0D) in OPA or OPB moves to CALC. Terminator in OPA (no operator) sets `err`. Terminator in OPB with no B digit sets `err`.
- Any other byte sets `err`; the state is unchanged.
- CALC: `+` gives A+B; `-` gives A−B, which may be negative; `*` gives A*B. Operands are zero-extended to RESW. No overflow is possible given RESW ≥ 2*OPW.
- OUT: `res_valid`=1. If `err`=1, then `res_err`=1 and `res_data`=0. Transfer occurs on a cycle with `res_valid` and `res_ready` both high, then go to IDLE.
- `rx_valid` bytes arriving in CALC or OUT are dropped without effect.

## Timing
- Reset values: `res_data`=0, `res_valid`=0, `res_err`=0, `busy`=0, state IDLE, all accumulators and flags 0.
- Each accepted byte is processed in the cycle after its `rx_valid` edge, with one byte per cycle maximum.
- For add/sub/mul, a terminator sampled on edge n gives CALC at n+1 and `res_valid`=1 after edge n+2.
- `res_data` and `res_err` are registered and stable while `res_valid`=1.
- If `res_ready` is already high when `res_valid` rises, the transfer completes in one cycle, `res_valid` drops after the next edge, and IDLE accepts a byte on the following cycle.
- Asserting `rst` mid-expression or mid-OUT returns to reset values immediately; a pending result is lost.

## Configuration
- `UART_CALC_DIV_EN` defined:
  - `/` (0x2F) is a legal operator.
  - CALC runs an OPW-cycle restoring divider producing the unsigned quotient A/B; the remainder is discarded.
  - Latency from terminator to `res_valid` is n+2+OPW.
  - B=0 gives `res_err`=1 and `res_data`=0.
  - `busy` is high throughout.
- Not defined: `/` is an illegal byte (sets `err`), and no divider logic is present.

## Test plan
- Bytes "12+34=" → `res_valid` 2 cycles after `=`, `res_data`=46, `res_err`=0; hold `res_ready`=0 for 5 cycles → outputs stable, then accepted.
- Bytes "5-9\r" → `res_data`=0xFFFFFFFC (−4), `res_err`=0.
- Bytes "65535*65535=" → `res_data`=0xFFFE0001; bytes "65536+1=" → `res_err`=1, `res_data`=0.
- Bytes "1 2 + x3=" → `res_err`=1 (illegal `x`); bytes "+3=" → `res_err`=1; bytes sent during OUT are ignored, and the next "2*3=" gives 6.
- Assert `rst` after "12+" → all outputs 0; then "7+1=" gives 8.
- With `UART_CALC_DIV_EN`: "100/7=" gives 14 after 2+OPW cycles; "5/0=" gives `res_err`=1. Without the macro, "100/7=" gives `res_err`=1.

Source files
------------

// File: rtl/uart_calc_parser.sv
// UART calculator: parses "<A><op><B><term>" from the RX byte stream and returns a signed result.
// Define UART_CALC_DIV_EN to add '/' with an OPW-cycle restoring divider.
//
// state  | meaning
// S_IDLE | waiting for first byte, accumulators cleared
// S_OPA  | accumulating operand A
// S_OPB  | operator latched, accumulating operand B
// S_CALC | evaluating (one cycle, or OPW+1 cycles for divide)
// S_OUT  | result held until res_ready
module uart_calc_parser #(
    parameter int OPW  = 16,
    parameter int RESW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    input  logic            res_ready,
    output logic [RESW-1:0] res_data,
    output logic            res_valid,
    output logic            res_err,
    output logic            busy
);

    typedef enum logic [2:0] {S_IDLE, S_OPA, S_OPB, S_CALC, S_OUT} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    state_e          state_q;
    op_e             op_q, op_d;
    logic [OPW-1:0]  acc_a_q, acc_b_q, acc_sel;
    logic            err_q, seen_a_q, seen_b_q;
    logic [7:0]      rx_byte_q;
    logic            rx_vld_q;
    logic [RESW-1:0] res_data_q, calc_d, a_ext, b_ext;
    logic            res_valid_q, res_err_q, busy_q, res_err_d;
    logic            is_digit, is_op, is_term, is_ign, acc_ovf, div_run;
    logic [OPW+3:0]  acc_wide_d;

`ifdef UART_CALC_DIV_EN
    localparam int CW = $clog2(OPW + 1);
    logic [OPW-1:0] rem_q, quo_q;
    logic [CW-1:0]  cnt_q;
    logic [OPW:0]   shifted, diff;
    logic           ge;
`endif

    always_comb begin
        is_digit = (rx_byte_q >= 8'h30) && (rx_byte_q <= 8'h39);
        is_term  = (rx_byte_q == 8'h3D) || (rx_byte_q == 8'h0D);
        is_ign   = (rx_byte_q == 8'h20) || (rx_byte_q == 8'h0A);
        is_op    = 1'b1;
        op_d     = OP_ADD;
        case (rx_byte_q)
            8'h2B:   op_d = OP_ADD;
            8'h2D:   op_d = OP_SUB;
            8'h2A:   op_d = OP_MUL;
`ifdef UART_CALC_DIV_EN
            8'h2F:   op_d = OP_DIV;
`endif
            default: is_op = 1'b0;
        endcase
        // Wide enough that acc*10+9 never wraps, so overflow is just the top bits.
        acc_sel    = (state_q == S_OPB) ? acc_b_q : acc_a_q;
        acc_wide_d = {4'b0000, acc_sel} * (OPW+4)'(10) + {{OPW{1'b0}}, rx_byte_q[3:0]};
        acc_ovf    = |acc_wide_d[OPW+3:OPW];

        a_ext     = {{(RESW-OPW){1'b0}}, acc_a_q};
        b_ext     = {{(RESW-OPW){1'b0}}, acc_b_q};
        res_err_d = err_q;
        div_run   = 1'b0;
        case (op_q)
            OP_SUB:  calc_d = a_ext - b_ext;
            OP_MUL:  calc_d = a_ext * b_ext;
            OP_DIV:  calc_d = '0;
            default: calc_d = a_ext + b_ext;
        endcase
`ifdef UART_CALC_DIV_EN
        shifted = {rem_q, quo_q[OPW-1]};
        diff    = shifted - {1'b0, acc_b_q};
        ge      = shifted >= {1'b0, acc_b_q};
        if (op_q == OP_DIV) begin
            calc_d  = {{(RESW-OPW){1'b0}}, quo_q};
            div_run = (cnt_q != '0);
            if (acc_b_q == '0) res_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            err_q       <= 1'b0;
            seen_a_q    <= 1'b0;
            seen_b_q    <= 1'b0;
            rx_byte_q   <= '0;
            rx_vld_q    <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_CALC_DIV_EN
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            // Bytes arriving while busy are dropped at the input register.
            rx_vld_q  <= rx_valid && (state_q != S_CALC) && (state_q != S_OUT);
            rx_byte_q <= rx_data;
            case (state_q)
                S_IDLE, S_OPA, S_OPB: begin
                    if (rx_vld_q && !is_ign) begin
                        if (is_digit) begin
                            if (acc_ovf) err_q <= 1'b1;
                            else if (state_q == S_OPB) acc_b_q <= acc_wide_d[OPW-1:0];
                            else acc_a_q <= acc_wide_d[OPW-1:0];
                            if (state_q == S_OPB) seen_b_q <= 1'b1;
                            else seen_a_q <= 1'b1;
                            if (state_q == S_IDLE) state_q <= S_OPA;
                        end else if ((is_op || is_term) && state_q == S_IDLE) begin
                            err_q   <= 1'b1;
                            state_q <= S_OPA;
                        end else if (is_op) begin
                            if (state_q == S_OPA) begin
                                op_q    <= op_d;
                                state_q <= S_OPB;
                                if (!seen_a_q) err_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (is_term) begin
                            if (state_q == S_OPA || !seen_b_q) err_q <= 1'b1;
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
`ifdef UART_CALC_DIV_EN
                            rem_q   <= '0;
                            quo_q   <= acc_a_q;
                            cnt_q   <= CW'(OPW);
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (div_run) begin
`ifdef UART_CALC_DIV_EN
                        rem_q <= ge ? diff[OPW-1:0] : shifted[OPW-1:0];
                        quo_q <= {quo_q[OPW-2:0], ge};
                        cnt_q <= cnt_q - CW'(1);
`endif
                    end else begin
                        state_q     <= S_OUT;
                        res_valid_q <= 1'b1;
                        res_err_q   <= res_err_d;
                        res_data_q  <= res_err_d ? '0 : calc_d;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        op_q        <= OP_ADD;
                        acc_a_q     <= '0;
                        acc_b_q     <= '0;
                        err_q       <= 1'b0;
                        seen_a_q    <= 1'b0;
                        seen_b_q    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_calc_parser.sv
// Scoreboard bench for uart_calc_parser: expected results queued as expressions are sent,
// popped and compared on each res_valid/res_ready transfer.
module tb_uart_calc_parser;

    localparam int OPW  = 16;
    localparam int RESW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            res_ready;
    logic [RESW-1:0] res_data;
    logic            res_valid;
    logic            res_err;
    logic            busy;

    typedef struct packed {
        logic [RESW-1:0] data;
        logic            err;
    } exp_t;

    exp_t sb_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   n_xfer = 0;

    uart_calc_parser #(.OPW(OPW), .RESW(RESW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("res_data", 64'(res_data), 64'(e.data));
                check("res_err", 64'(res_err), 64'(e.err));
            end
            n_xfer++;
        end
    end

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_xfer(input string tag, input int start);
        for (int k = 0; k < 20 && n_xfer == start; k++) begin
            @(posedge clk); #1;
        end
        check({tag, "_xfer"}, 64'(n_xfer), 64'(start + 1));
        check({tag, "_vdrop"}, 64'(res_valid), 64'd0);
        check({tag, "_bdrop"}, 64'(busy), 64'd0);
    endtask

    task automatic expr(input string tag, input string s, input logic [RESW-1:0] d,
                        input logic e, input int lat);
        exp_t x;
        int   cyc;
        int   start;
        x.data = d;
        x.err  = e;
        sb_q.push_back(x);
        start = n_xfer;
        send(s);
        wait_valid(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        if (res_ready) wait_xfer(tag, start);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 64'(res_data), 64'd0);
        check({tag, "_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_err"}, 64'(res_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int start;
        int cyc;
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Held result must stay put while downstream stalls.
        res_ready = 1'b0;
        expr("add", "12+34=", 32'd46, 1'b0, 2);
        start = n_xfer;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_data", 64'(res_data), 64'd46);
            check("hold_err", 64'(res_err), 64'd0);
        end
        res_ready = 1'b1;
        wait_xfer("hold", start);

        expr("sub_neg", "5-9\015", 32'hFFFF_FFFC, 1'b0, 2);
        expr("mul_max", "65535*65535=", 32'hFFFE_0001, 1'b0, 2);
        expr("ovf", "65536+1=", 32'd0, 1'b1, 2);
        expr("illegal", "1 2 + x3=", 32'd0, 1'b1, 2);
        expr("no_a", "+3=", 32'd0, 1'b1, 2);
        expr("no_b", "8*=", 32'd0, 1'b1, 2);

        // Bytes sent while the result is pending are dropped.
        res_ready = 1'b0;
        expr("pre_drop", "1+1=", 32'd2, 1'b0, 2);
        start = n_xfer;
        send("9*9=");
        check("drop_valid", 64'(res_valid), 64'd1);
        check("drop_data", 64'(res_data), 64'd2);
        res_ready = 1'b1;
        wait_xfer("drop", start);
        expr("after_drop", "2*3=", 32'd6, 1'b0, 2);

        send("12+");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        expr("post_rst", "7+1=", 32'd8, 1'b0, 2);

        // Reset while a result is pending discards it.
        res_ready = 1'b0;
        send("4+4=");
        wait_valid(cyc);
        check("rst_out_pre", 64'(res_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_out");
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        expr("sub_neg2", "3-10=", 32'hFFFF_FFF9, 1'b0, 2);

`ifdef UART_CALC_DIV_EN
        expr("div", "100/7=", 32'd14, 1'b0, 2 + OPW);
        expr("div0", "5/0=", 32'd0, 1'b1, 2 + OPW);
`else
        expr("div_off", "100/7=", 32'd0, 1'b1, 2);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
